// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  // Receive frame FSM states
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_PUSH,
    S_WAIT_IDLE
  } rx_state_e;

  // Parity mode encodings
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Bit timer width
  localparam int unsigned CNT_W = 32;

  // Clock cycles per bit period; 64-bit intermediate avoids overflow of MHz*1e6
  function automatic int unsigned delay_frames(input int unsigned fmax_mhz,
                                               input int unsigned baud);
    logic [63:0] hz;
    hz = 64'(fmax_mhz) * 64'd1000000;
    return 32'(hz / 64'(baud));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; dout reads zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the same-cycle push needs
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: synchroniser, frame FSM with start-glitch rejection,
// parity/framing checks and a buffered valid/ready output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned FMAX_MHz   = 27,
  parameter int unsigned BaudRate   = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rdata,
  output logic                          rdata_valid,
  input  logic                          rdata_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DELAY    = delay_frames(FMAX_MHz, BaudRate);
  localparam int unsigned HALF     = DELAY / 2;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);
  localparam int unsigned EW       = DATA_BITS + 2;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 sync1_q, sync1_d;
  logic                 rx_s_q, rx_s_d;
  logic                 overrun_q, overrun_d;
  logic                 push_c;
  logic                 par_chk_c;

  logic [EW-1:0]        fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop_fire_c;

  // Frame FSM next-state, bit timer and per-frame accumulators
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    push_c    = 1'b0;
    par_chk_c = par_q ^ rx_s_q;
    sync1_d   = uart_rx;
    rx_s_d    = sync1_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_END) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            shift_d = '0;
            par_d   = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          par_d          = par_q ^ rx_s_q;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_END) begin
          perr_d  = (PARITY == PAR_EVEN) ? par_chk_c : ~par_chk_c;
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (!rx_s_q) ferr_d = 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) state_d = S_PUSH;
          else                             stop_d  = 1'b1;
        end
      end
      S_PUSH: begin
        push_c  = 1'b1;
        state_d = ferr_q ? S_WAIT_IDLE : S_IDLE;
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // Sticky overrun: set by a dropped frame, cleared by the next accepted pop
  always_comb begin
    pop_fire_c = rdata_ready && !fifo_empty;
    overrun_d  = overrun_q;
    if (push_c && fifo_full && !pop_fire_c) overrun_d = 1'b1;
    else if (pop_fire_c)                    overrun_d = 1'b0;
  end

  // State, synchroniser and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      overrun_q <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .din   ({perr_q, ferr_q, shift_q}),
    .pop   (rdata_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign rdata       = fifo_dout[DATA_BITS-1:0];
  assign frame_err   = fifo_dout[DATA_BITS];
  assign parity_err  = fifo_dout[DATA_BITS+1];
  assign rdata_valid = !fifo_empty;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: three configurations (8N1/4, 7E1/4, 6O2/8).
module tb_uart_receiver;

  localparam int BIT_T = 10;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       perr;
    logic       ovr;
    logic [4:0] count;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } ent_t;

  typedef struct {
    logic [6:0] data;
    logic       par;
    logic       stop;
    logic [6:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       rx_a, rx_b, rx_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic [7:0] rdata_a;
  logic [6:0] rdata_b;
  logic [5:0] rdata_c;
  logic       valid_a, valid_b, valid_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       perr_a, perr_b, perr_c;
  logic       ovr_a, ovr_b, ovr_c;
  logic [2:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;

  int nb_cfg    [3] = '{8, 7, 6};
  int par_cfg   [3] = '{0, 2, 1};
  int stop_cfg  [3] = '{1, 1, 2};
  int depth_cfg [3] = '{4, 4, 8};

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t mq[$];
  logic m_ovr;
  vec_t vecs [7];

  uart_receiver #(.FMAX_MHz(1), .BaudRate(100000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .uart_rx(rx_a), .rdata(rdata_a), .rdata_valid(valid_a),
    .rdata_ready(rdy_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a),
    .fifo_count(cnt_a));

  uart_receiver #(.FMAX_MHz(1), .BaudRate(100000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .uart_rx(rx_b), .rdata(rdata_b), .rdata_valid(valid_b),
    .rdata_ready(rdy_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b),
    .fifo_count(cnt_b));

  uart_receiver #(.FMAX_MHz(1), .BaudRate(100000), .DATA_BITS(6), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(8)) dut_c (
    .clk(clk), .reset(reset), .uart_rx(rx_c), .rdata(rdata_c), .rdata_valid(valid_c),
    .rdata_ready(rdy_c), .frame_err(ferr_c), .parity_err(perr_c), .overrun(ovr_c),
    .fifo_count(cnt_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int d, input logic v);
    case (d)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic set_rdy(input int d, input logic v);
    case (d)
      0:       rdy_a = v;
      1:       rdy_b = v;
      default: rdy_c = v;
    endcase
  endtask

  function automatic obs_t observe(input int d);
    obs_t o;
    case (d)
      0: begin
        o.data = rdata_a; o.valid = valid_a; o.ferr = ferr_a;
        o.perr = perr_a;  o.ovr = ovr_a;     o.count = 5'(cnt_a);
      end
      1: begin
        o.data = 8'(rdata_b); o.valid = valid_b; o.ferr = ferr_b;
        o.perr = perr_b;      o.ovr = ovr_b;     o.count = 5'(cnt_b);
      end
      default: begin
        o.data = 8'(rdata_c); o.valid = valid_c; o.ferr = ferr_c;
        o.perr = perr_c;      o.ovr = ovr_c;     o.count = 5'(cnt_c);
      end
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int d, input logic v, input int n);
    set_rx(d, v);
    repeat (n) tick();
  endtask

  task automatic pop_one(input int d);
    set_rdy(d, 1'b1);
    tick();
    set_rdy(d, 1'b0);
  endtask

  // Compare every output of one receiver against the reference queue
  task automatic check_model(input int d, input string tag);
    obs_t o;
    o = observe(d);
    check($sformatf("d%0d %s count", d, tag), 32'(o.count), 32'(mq.size()));
    check($sformatf("d%0d %s valid", d, tag), 32'(o.valid), 32'(mq.size() > 0));
    check($sformatf("d%0d %s overrun", d, tag), 32'(o.ovr), 32'(m_ovr));
    if (mq.size() > 0) begin
      check($sformatf("d%0d %s data", d, tag), 32'(o.data), 32'(mq[0].data));
      check($sformatf("d%0d %s ferr", d, tag), 32'(o.ferr), 32'(mq[0].ferr));
      check($sformatf("d%0d %s perr", d, tag), 32'(o.perr), 32'(mq[0].perr));
    end else begin
      check($sformatf("d%0d %s data", d, tag), 32'(o.data), 32'd0);
      check($sformatf("d%0d %s ferr", d, tag), 32'(o.ferr), 32'd0);
      check($sformatf("d%0d %s perr", d, tag), 32'(o.perr), 32'd0);
    end
  endtask

  // Serialise one frame for receiver d and record the expected FIFO effect.
  // pop_at_push raises rdata_ready exactly on the edge that writes the frame.
  task automatic send_frame(input int d, input logic [7:0] data, input logic flip_par,
                            input logic [1:0] stop_low, input logic pop_at_push);
    logic bits[$];
    logic [7:0] dm;
    logic pb;
    ent_t e;
    int len;
    int ones;
    dm = data & 8'((9'd1 << nb_cfg[d]) - 9'd1);
    pb = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb_cfg[d]; i++) bits.push_back(dm[i]);
    if (par_cfg[d] != 0) begin
      pb = ^dm;
      if (par_cfg[d] == 1) pb = ~pb;
      pb = pb ^ flip_par;
      bits.push_back(pb);
    end
    for (int s = 0; s < stop_cfg[d]; s++) bits.push_back(~stop_low[s]);
    len = bits.size();
    for (int t = 0; t < len * BIT_T; t++) begin
      if (t % BIT_T == 0) set_rx(d, bits[t / BIT_T]);
      if (pop_at_push && t == len * BIT_T - 2) set_rdy(d, 1'b1);
      if (pop_at_push && t == len * BIT_T - 1) set_rdy(d, 1'b0);
      tick();
    end
    e.data = dm;
    e.ferr = (stop_cfg[d] == 1) ? stop_low[0] : (stop_low[0] | stop_low[1]);
    ones   = $countones(dm) + int'(pb);
    if (par_cfg[d] == 0)      e.perr = 1'b0;
    else if (par_cfg[d] == 2) e.perr = (ones % 2) == 1;
    else                      e.perr = (ones % 2) == 0;
    if (pop_at_push && mq.size() > 0) begin
      void'(mq.pop_front());
      m_ovr = 1'b0;
    end
    if (mq.size() >= depth_cfg[d]) m_ovr = 1'b1;
    else                           mq.push_back(e);
  endtask

  initial begin
    obs_t o;
    int   np;
    logic [7:0] v;
    logic flip;
    logic [1:0] sl;

    vecs[0] = '{7'h41, 1'b1, 1'b1, 7'h41, 1'b1, 1'b0};
    vecs[1] = '{7'h41, 1'b0, 1'b1, 7'h41, 1'b0, 1'b0};
    vecs[2] = '{7'h7F, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0};
    vecs[3] = '{7'h7F, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b0};
    vecs[4] = '{7'h00, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0};
    vecs[5] = '{7'h2A, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b1};
    vecs[6] = '{7'h13, 1'b0, 1'b1, 7'h13, 1'b1, 1'b0};

    reset = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    repeat (3) tick();

    // Reset state
    check("reset rdata", 32'(rdata_a), 32'd0);
    check("reset valid", 32'(valid_a), 32'd0);
    check("reset ferr", 32'(ferr_a), 32'd0);
    check("reset perr", 32'(perr_a), 32'd0);
    check("reset overrun", 32'(ovr_a), 32'd0);
    check("reset count", 32'(cnt_a), 32'd0);
    check("reset count b", 32'(cnt_b), 32'd0);
    reset = 1'b0;
    repeat (5) tick();

    // 8N1 0xA5: exact push latency after the stop-bit centre
    v = 8'hA5;
    drive_bit(0, 1'b0, BIT_T);
    for (int i = 0; i < 8; i++) drive_bit(0, v[i], BIT_T);
    drive_bit(0, 1'b1, BIT_T - 2);
    check("t1 valid during push", 32'(valid_a), 32'd0);
    tick();
    check("t1 valid", 32'(valid_a), 32'd1);
    check("t1 data", 32'(rdata_a), 32'hA5);
    check("t1 ferr", 32'(ferr_a), 32'd0);
    check("t1 perr", 32'(perr_a), 32'd0);
    check("t1 count", 32'(cnt_a), 32'd1);
    tick();
    pop_one(0);
    check("t1 pop count", 32'(cnt_a), 32'd0);
    check("t1 pop data", 32'(rdata_a), 32'd0);

    // Start glitch shorter than half a bit
    drive_bit(0, 1'b0, 3);
    drive_bit(0, 1'b1, 20);
    check("glitch count", 32'(cnt_a), 32'd0);
    check("glitch valid", 32'(valid_a), 32'd0);
    send_frame(0, 8'h5A, 1'b0, 2'b00, 1'b0);
    check("post-glitch data", 32'(rdata_a), 32'h5A);
    check("post-glitch count", 32'(cnt_a), 32'd1);
    pop_one(0);

    // Break: one zero entry with framing error, then normal reception
    drive_bit(0, 1'b0, 30 * BIT_T);
    drive_bit(0, 1'b1, 5);
    check("break count", 32'(cnt_a), 32'd1);
    check("break data", 32'(rdata_a), 32'd0);
    check("break ferr", 32'(ferr_a), 32'd1);
    pop_one(0);
    check("break drained", 32'(cnt_a), 32'd0);
    send_frame(0, 8'h55, 1'b0, 2'b00, 1'b0);
    drive_bit(0, 1'b1, 2);
    check("after break data", 32'(rdata_a), 32'h55);
    check("after break ferr", 32'(ferr_a), 32'd0);
    check("after break count", 32'(cnt_a), 32'd1);
    pop_one(0);

    // Overrun with depth 4
    for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 2'b00, 1'b0);
    check("ovr count", 32'(cnt_a), 32'd4);
    check("ovr flag", 32'(ovr_a), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovr pop %0d data", k), 32'(rdata_a), 32'(k));
      pop_one(0);
      if (k == 1) check("ovr cleared", 32'(ovr_a), 32'd0);
    end
    check("ovr drained", 32'(cnt_a), 32'd0);

    // Push and pop on the same edge while full
    for (int k = 0; k < 4; k++) send_frame(0, 8'(8'h10 + k), 1'b0, 2'b00, 1'b0);
    send_frame(0, 8'h14, 1'b0, 2'b00, 1'b1);
    check("full pp count", 32'(cnt_a), 32'd4);
    check("full pp overrun", 32'(ovr_a), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("full pp head %0d", k), 32'(rdata_a), 32'(8'h10 + k));
      pop_one(0);
    end

    // Push and pop on the same edge while empty
    send_frame(0, 8'h99, 1'b0, 2'b00, 1'b1);
    check("empty pp count", 32'(cnt_a), 32'd1);
    check("empty pp data", 32'(rdata_a), 32'h99);

    // Reset in the middle of data bit 3
    v = 8'hC3;
    drive_bit(0, 1'b0, BIT_T);
    for (int i = 0; i < 3; i++) drive_bit(0, v[i], BIT_T);
    drive_bit(0, v[3], BIT_T / 2);
    reset = 1'b1;
    tick();
    check("midreset rdata", 32'(rdata_a), 32'd0);
    check("midreset valid", 32'(valid_a), 32'd0);
    check("midreset ferr", 32'(ferr_a), 32'd0);
    check("midreset perr", 32'(perr_a), 32'd0);
    check("midreset overrun", 32'(ovr_a), 32'd0);
    check("midreset count", 32'(cnt_a), 32'd0);
    reset = 1'b0;
    drive_bit(0, 1'b1, 20);
    check("midreset no push", 32'(cnt_a), 32'd0);
    send_frame(0, 8'h3C, 1'b0, 2'b00, 1'b0);
    drive_bit(0, 1'b1, 2);
    check("after reset data", 32'(rdata_a), 32'h3C);
    check("after reset count", 32'(cnt_a), 32'd1);
    check("after reset ferr", 32'(ferr_a), 32'd0);
    pop_one(0);

    // 7E1 vector table
    for (int k = 0; k < 7; k++) begin
      drive_bit(1, 1'b0, BIT_T);
      for (int i = 0; i < 7; i++) drive_bit(1, vecs[k].data[i], BIT_T);
      drive_bit(1, vecs[k].par, BIT_T);
      drive_bit(1, vecs[k].stop, BIT_T);
      drive_bit(1, 1'b1, 3);
      o = observe(1);
      check($sformatf("vec%0d count", k), 32'(o.count), 32'd1);
      check($sformatf("vec%0d data", k), 32'(o.data), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d perr", k), 32'(o.perr), 32'(vecs[k].exp_perr));
      check($sformatf("vec%0d ferr", k), 32'(o.ferr), 32'(vecs[k].exp_ferr));
      pop_one(1);
      check($sformatf("vec%0d drained", k), 32'(observe(1).count), 32'd0);
    end

    // Randomised traffic on every configuration against the queue model
    for (int d = 0; d < 3; d++) begin
      mq.delete();
      m_ovr = 1'b0;
      check_model(d, "rand start");
      for (int f = 0; f < 25; f++) begin
        v    = 8'($urandom);
        flip = (par_cfg[d] != 0) && ($urandom_range(0, 3) == 0);
        sl   = 2'b00;
        if ($urandom_range(0, 5) == 0)
          sl = (stop_cfg[d] == 1) ? 2'b01 : 2'($urandom_range(1, 3));
        send_frame(d, v, flip, sl, $urandom_range(0, 4) == 0);
        drive_bit(d, 1'b1, (sl != 2'b00) ? 3 : int'($urandom_range(0, 3)));
        check_model(d, $sformatf("frame %0d", f));
        np = int'($urandom_range(0, 2));
        for (int p = 0; p < np; p++) begin
          pop_one(d);
          if (mq.size() > 0) begin
            void'(mq.pop_front());
            m_ovr = 1'b0;
          end
          check_model(d, $sformatf("frame %0d pop %0d", f, p));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
